stack_sequencer: RTL and testbench
==================================

# stack_sequencer

Sequencing controller for the hardware stack: accepts push/pop/peek requests over a valid/ready handshake and drives the stack-pointer control lines, the memory write/select strobes and the shared 16-bit bus in the correct cycle order. It sits between the instruction decoder (requester) and the `stackpointer` / `memorystack` pair. It tracks logical depth so it can reject overflow and underflow without touching memory.

## Interface
- DEPTH_MAX, 256, maximum number of stacked words (1..65535); push at this depth is an overflow.
- i_clock  input  1  system clock, rising-edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_req_valid  input  1  request present.
- o_req_ready  output  1  high only in IDLE; request accepted on the edge where valid&ready.
- i_op  input  [0:1]  00 push, 01 pop, 10 peek, 11 illegal.
- i_wdata  input  [0:15]  push data, sampled at accept.
- bus  inout  [0:15]  shared datapath bus; driven by this block only in PUSH_WR, else 16'bz.
- o_sp_ctrl  output  [0:2]  to stackpointer: [0] SP-to-bus enable (always 0 here); [1:2]=01 increment, 10 decrement, 00 hold.
- o_mem_w  output  1  memory write strobe (writes bus to memory[SP] on edge).
- o_mem_s  output  1  memory bus select; 0 = memory drives bus, 1 = released.
- o_rsp_valid  output  1  one-cycle response pulse.
- o_rdata  output  [0:15]  pop/peek data, valid with o_rsp_valid, held until next capture.
- o_err  output  1  qualifies o_rsp_valid: overflow, underflow or illegal op.
- o_depth  output  [0:15]  current logical depth.

## Operation
- SP points at the top element; empty stack = SP base. Push = increment then write; pop = read then decrement.
- States: IDLE, PUSH_INC, PUSH_WR, READ, RESP.
- IDLE: o_req_ready=1. On accept: latch op and i_wdata; choose next state:
  - push, depth<DEPTH_MAX -> PUSH_INC; push, depth==DEPTH_MAX -> RESP with err.
  - pop/peek, depth>0 -> READ; depth==0 -> RESP with err.
  - op 11 -> RESP with err. Error paths issue no sp_ctrl, mem_w or bus activity, and depth is unchanged.
- PUSH_INC: o_sp_ctrl=3'b001 -> PUSH_WR.
- PUSH_WR: bus=latched data, o_mem_w=1, depth+1 -> RESP.
- READ: o_mem_s=0; o_rdata<=bus at edge.
  - Pop: o_sp_ctrl=3'b010 in the same cycle, depth-1.
  - Peek: o_sp_ctrl=000.
  - -> RESP.
- RESP: o_rsp_valid=1, o_err as determined -> IDLE. No response backpressure.
- Outside the stated states, outputs idle: sp_ctrl=000, mem_w=0, mem_s=1, bus=z.

## Timing
- Reset (async, immediate):
  - State IDLE; o_depth=0, o_rdata=0, o_rsp_valid=0, o_err=0, o_mem_w=0, o_mem_s=1, o_sp_ctrl=000, bus=z.
  - o_req_ready=1 as soon as reset deasserts.
- Reset mid-operation aborts with no further strobes. SP is not restored by this block; the system reinitialises SP on reset.
- Latency from accept edge to the o_rsp_valid cycle:
  - Push: 3 cycles (PUSH_INC, PUSH_WR, RESP).
  - Pop/peek: 2 cycles (READ, RESP).
  - Error: 1 cycle (RESP).
- Throughput: next accept is possible in the cycle after RESP, so one push per 4 cycles.
- o_mem_w and o_mem_s=0 are never asserted in the same cycle. The block never drives the bus while o_mem_s=0.
- o_depth updates on the edge leaving PUSH_WR (increment) or leaving READ for pop (decrement). It never wraps; it saturates by rejection.
- Requests while not ready are ignored; the requester holds valid.

## Test plan
- Reset, push 16'hA5A5 -> sp_ctrl=001 at +1 cycle, bus=A5A5 with mem_w=1 at +2, rsp_valid at +3 with err=0, depth=1.
- Push 1,2,3 then pop three times -> o_rdata 3,2,1 with err=0, depth back to 0, sp_ctrl=010 once per pop.
- Peek after pushing 16'h1234 twice -> rdata=1234, depth stays 2, no decrement strobe.
- Pop at depth 0 and op 11 -> rsp_valid one cycle after accept with err=1; no mem/sp/bus activity; depth 0.
- DEPTH_MAX=4: five pushes -> fifth returns err=1, depth stays 4, mem_w not asserted.
- Assert i_reset during PUSH_WR -> all strobes drop immediately, bus=z, depth=0, ready=1 after release.

Source files
------------

// File: rtl/stack_sequencer_if.sv
// Request/response and stack-control bundle between the instruction decoder,
// the stack sequencer and the stackpointer/memorystack pair.
interface stack_sequencer_if;
   // Request accepted on the rising edge where i_req_valid and o_req_ready are both 1;
   // the requester holds valid/op/wdata until then. Responses are a single-cycle
   // o_rsp_valid pulse with no backpressure.
   logic        i_req_valid;
   logic        o_req_ready;
   logic [1:0]  i_op;
   logic [15:0] i_wdata;
   logic [2:0]  o_sp_ctrl;
   logic        o_mem_w;
   logic        o_mem_s;
   logic        o_rsp_valid;
   logic [15:0] o_rdata;
   logic        o_err;
   logic [15:0] o_depth;

   modport slave (
      input  i_req_valid, i_op, i_wdata,
      output o_req_ready, o_sp_ctrl, o_mem_w, o_mem_s,
      output o_rsp_valid, o_rdata, o_err, o_depth
   );

   modport master (
      output i_req_valid, i_op, i_wdata,
      input  o_req_ready, o_sp_ctrl, o_mem_w, o_mem_s,
      input  o_rsp_valid, o_rdata, o_err, o_depth
   );
endinterface

// File: rtl/stack_sequencer.sv
// Sequences push/pop/peek requests into stackpointer/memory strobes and bus
// drive, tracking logical depth so overflow/underflow never touch memory.
module stack_sequencer #(
   parameter int unsigned DEPTH_MAX = 256
) (
   input  logic                i_clock,
   input  logic                i_reset,
   stack_sequencer_if.slave    sif,
   inout  wire  [15:0]         bus,
   output logic [2:0]          o_state
);

   localparam logic [15:0] DEPTH_MAX_W = 16'(DEPTH_MAX);
   localparam logic [1:0]  OP_PUSH = 2'b00;
   localparam logic [1:0]  OP_POP  = 2'b01;
   localparam logic [1:0]  OP_PEEK = 2'b10;

   // sp_ctrl value: bit 2 = SP-to-bus enable, bits 1:0 = 01 inc, 10 dec, 00 hold
   localparam logic [2:0]  SP_HOLD = 3'b000;
   localparam logic [2:0]  SP_INC  = 3'b001;
   localparam logic [2:0]  SP_DEC  = 3'b010;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PUSH_INC = 3'd1,
      PUSH_WR  = 3'd2,
      READ     = 3'd3,
      RESP     = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] depth_q, depth_d;
   logic [15:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        req_ready;
   logic [2:0]  sp_ctrl;
   logic        mem_w;
   logic        mem_s;
   logic        bus_oe;
   logic        rsp_valid;
   logic        rsp_err;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         op_q    <= 2'b00;
         wdata_q <= 16'h0000;
         depth_q <= 16'h0000;
         rdata_q <= 16'h0000;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         wdata_q <= wdata_d;
         depth_q <= depth_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      wdata_d   = wdata_q;
      depth_d   = depth_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      req_ready = 1'b0;
      sp_ctrl   = SP_HOLD;
      mem_w     = 1'b0;
      mem_s     = 1'b1;
      bus_oe    = 1'b0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;

      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (sif.i_req_valid) begin
               op_d    = sif.i_op;
               wdata_d = sif.i_wdata;
               // Rejected requests go straight to RESP without any strobes.
               if (sif.i_op == OP_PUSH) begin
                  err_d   = (depth_q == DEPTH_MAX_W);
                  state_d = (depth_q == DEPTH_MAX_W) ? RESP : PUSH_INC;
               end else if (sif.i_op == OP_POP || sif.i_op == OP_PEEK) begin
                  err_d   = (depth_q == 16'h0000);
                  state_d = (depth_q == 16'h0000) ? RESP : READ;
               end else begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end
         PUSH_INC: begin
            sp_ctrl = SP_INC;
            state_d = PUSH_WR;
         end
         PUSH_WR: begin
            bus_oe  = 1'b1;
            mem_w   = 1'b1;
            depth_d = depth_q + 16'd1;
            state_d = RESP;
         end
         READ: begin
            mem_s   = 1'b0;
            rdata_d = bus;
            if (op_q == OP_POP) begin
               sp_ctrl = SP_DEC;
               depth_d = depth_q - 16'd1;
            end
            state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus             = bus_oe ? wdata_q : 16'bz;
   assign sif.o_req_ready = req_ready;
   assign sif.o_sp_ctrl   = sp_ctrl;
   assign sif.o_mem_w     = mem_w;
   assign sif.o_mem_s     = mem_s;
   assign sif.o_rsp_valid = rsp_valid;
   assign sif.o_err       = rsp_err;
   assign sif.o_rdata     = rdata_q;
   assign sif.o_depth     = depth_q;
   assign o_state         = state_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a small stackpointer/memory model
// on the shared bus; DEPTH_MAX is 4 so the overflow boundary is reachable.
module tb_stack_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stack_sequencer_if sif();
   wire  [15:0] bus;
   logic [2:0]  dbg_state;

   stack_sequencer #(.DEPTH_MAX(4)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .sif     (sif),
      .bus     (bus),
      .o_state (dbg_state)
   );

   // stackpointer + memorystack model
   logic [15:0] mem [0:15];
   logic [7:0]  sp;

   assign bus = (!sif.o_mem_s) ? mem[sp[3:0]] : 16'bz;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sp <= 8'd0;
      end else begin
         if (sif.o_sp_ctrl == 3'b001) sp <= sp + 8'd1;
         else if (sif.o_sp_ctrl == 3'b010) sp <= sp - 8'd1;
         if (sif.o_mem_w) mem[sp[3:0]] <= bus;
      end
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one request and check the whole response window against the spec.
   task automatic do_op(input string tag, input logic [1:0] op, input logic [15:0] d,
                        input int exp_lat, input logic exp_err, input logic chk_rd,
                        input logic [15:0] exp_rd, input logic [15:0] exp_depth);
      int lat, n_inc, n_dec, n_w, n_rd, inc_cyc, w_cyc, conflict, waitc;
      logic [15:0] w_bus, rd;
      logic err_s, good;
      good = !exp_err;
      lat = 0; n_inc = 0; n_dec = 0; n_w = 0; n_rd = 0;
      inc_cyc = 0; w_cyc = 0; conflict = 0; waitc = 0;
      w_bus = 16'h0; rd = 16'h0; err_s = 1'b0;
      @(negedge clk);
      sif.i_req_valid = 1'b1;
      sif.i_op        = op;
      sif.i_wdata     = d;
      while (!sif.o_req_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      check({tag, "_ready"}, 32'(sif.o_req_ready), 32'd1);
      @(posedge clk);
      #1;
      sif.i_req_valid = 1'b0;
      sif.i_op        = 2'b00;
      sif.i_wdata     = 16'h0000;
      for (int k = 1; k <= 6 && lat == 0; k++) begin
         @(negedge clk);
         if (sif.o_sp_ctrl == 3'b001) begin n_inc++; inc_cyc = k; end
         if (sif.o_sp_ctrl == 3'b010) n_dec++;
         if (sif.o_mem_w) begin n_w++; w_cyc = k; w_bus = bus; end
         if (!sif.o_mem_s) n_rd++;
         if (sif.o_mem_w && !sif.o_mem_s) conflict++;
         if (sif.o_rsp_valid) begin lat = k; err_s = sif.o_err; rd = sif.o_rdata; end
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_err"}, 32'(err_s), 32'(exp_err));
      check({tag, "_depth"}, 32'(sif.o_depth), 32'(exp_depth));
      check({tag, "_sp_inc"}, 32'(n_inc), 32'((op == 2'b00 && good) ? 1 : 0));
      check({tag, "_sp_dec"}, 32'(n_dec), 32'((op == 2'b01 && good) ? 1 : 0));
      check({tag, "_mem_w"}, 32'(n_w), 32'((op == 2'b00 && good) ? 1 : 0));
      check({tag, "_mem_rd"}, 32'(n_rd), 32'(((op == 2'b01 || op == 2'b10) && good) ? 1 : 0));
      check({tag, "_w_rd_overlap"}, 32'(conflict), 32'd0);
      if (op == 2'b00 && good) begin
         check({tag, "_inc_cycle"}, 32'(inc_cyc), 32'd1);
         check({tag, "_wr_cycle"}, 32'(w_cyc), 32'd2);
         check({tag, "_wr_bus"}, 32'(w_bus), 32'(d));
      end
      if (chk_rd) check({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
      @(negedge clk);
      check({tag, "_ready_after"}, 32'(sif.o_req_ready), 32'd1);
      check({tag, "_rsp_pulse"}, 32'(sif.o_rsp_valid), 32'd0);
   endtask

   initial begin
      rst             = 1'b1;
      sif.i_req_valid = 1'b0;
      sif.i_op        = 2'b00;
      sif.i_wdata     = 16'h0000;
      #1;
      check("rst_depth", 32'(sif.o_depth), 32'd0);
      check("rst_rdata", 32'(sif.o_rdata), 32'd0);
      check("rst_rsp_valid", 32'(sif.o_rsp_valid), 32'd0);
      check("rst_err", 32'(sif.o_err), 32'd0);
      check("rst_mem_w", 32'(sif.o_mem_w), 32'd0);
      check("rst_mem_s", 32'(sif.o_mem_s), 32'd1);
      check("rst_sp_ctrl", 32'(sif.o_sp_ctrl), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_ready", 32'(sif.o_req_ready), 32'd1);

      // single push then pop
      do_op("push_a5", 2'b00, 16'hA5A5, 3, 1'b0, 1'b0, 16'h0, 16'd1);
      do_op("pop_a5",  2'b01, 16'h0000, 2, 1'b0, 1'b1, 16'hA5A5, 16'd0);

      // LIFO order
      do_op("push_1", 2'b00, 16'h0001, 3, 1'b0, 1'b0, 16'h0, 16'd1);
      do_op("push_2", 2'b00, 16'h0002, 3, 1'b0, 1'b0, 16'h0, 16'd2);
      do_op("push_3", 2'b00, 16'h0003, 3, 1'b0, 1'b0, 16'h0, 16'd3);
      do_op("pop_3",  2'b01, 16'h0000, 2, 1'b0, 1'b1, 16'h0003, 16'd2);
      do_op("pop_2",  2'b01, 16'h0000, 2, 1'b0, 1'b1, 16'h0002, 16'd1);
      do_op("pop_1",  2'b01, 16'h0000, 2, 1'b0, 1'b1, 16'h0001, 16'd0);

      // peek leaves depth alone
      do_op("push_1234a", 2'b00, 16'h1234, 3, 1'b0, 1'b0, 16'h0, 16'd1);
      do_op("push_1234b", 2'b00, 16'h1234, 3, 1'b0, 1'b0, 16'h0, 16'd2);
      do_op("peek_1234",  2'b10, 16'h0000, 2, 1'b0, 1'b1, 16'h1234, 16'd2);
      do_op("pop_1234b",  2'b01, 16'h0000, 2, 1'b0, 1'b1, 16'h1234, 16'd1);
      do_op("pop_1234a",  2'b01, 16'h0000, 2, 1'b0, 1'b1, 16'h1234, 16'd0);

      // underflow, empty peek and illegal op
      do_op("pop_empty",  2'b01, 16'h0000, 1, 1'b1, 1'b0, 16'h0, 16'd0);
      do_op("peek_empty", 2'b10, 16'h0000, 1, 1'b1, 1'b0, 16'h0, 16'd0);
      do_op("illegal",    2'b11, 16'hFFFF, 1, 1'b1, 1'b0, 16'h0, 16'd0);

      // fill to DEPTH_MAX=4, then overflow
      do_op("fill_10", 2'b00, 16'h0010, 3, 1'b0, 1'b0, 16'h0, 16'd1);
      do_op("fill_11", 2'b00, 16'h0011, 3, 1'b0, 1'b0, 16'h0, 16'd2);
      do_op("fill_12", 2'b00, 16'h0012, 3, 1'b0, 1'b0, 16'h0, 16'd3);
      do_op("fill_13", 2'b00, 16'h0013, 3, 1'b0, 1'b0, 16'h0, 16'd4);
      do_op("overflow", 2'b00, 16'h0014, 1, 1'b1, 1'b0, 16'h0, 16'd4);
      do_op("peek_top", 2'b10, 16'h0000, 2, 1'b0, 1'b1, 16'h0013, 16'd4);
      do_op("pop_top",  2'b01, 16'h0000, 2, 1'b0, 1'b1, 16'h0013, 16'd3);

      // reset in the middle of PUSH_WR
      @(negedge clk);
      sif.i_req_valid = 1'b1;
      sif.i_op        = 2'b00;
      sif.i_wdata     = 16'hBEEF;
      @(posedge clk);
      #1;
      sif.i_req_valid = 1'b0;
      @(negedge clk);
      check("mid_inc", 32'(sif.o_sp_ctrl), 32'd1);
      @(negedge clk);
      check("mid_wr_strobe", 32'(sif.o_mem_w), 32'd1);
      check("mid_wr_bus", 32'(bus), 32'hBEEF);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_mem_w", 32'(sif.o_mem_w), 32'd0);
      check("mid_rst_mem_s", 32'(sif.o_mem_s), 32'd1);
      check("mid_rst_sp_ctrl", 32'(sif.o_sp_ctrl), 32'd0);
      check("mid_rst_rsp", 32'(sif.o_rsp_valid), 32'd0);
      check("mid_rst_depth", 32'(sif.o_depth), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_ready", 32'(sif.o_req_ready), 32'd1);
      @(posedge clk);
      #1;
      check("mid_rst_quiet", 32'(sif.o_mem_w), 32'd0);
      check("mid_rst_no_rsp", 32'(sif.o_rsp_valid), 32'd0);

      do_op("post_push", 2'b00, 16'h0007, 3, 1'b0, 1'b0, 16'h0, 16'd1);
      do_op("post_pop",  2'b01, 16'h0000, 2, 1'b0, 1'b1, 16'h0007, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
